// File: rtl/systolic_axis_feeder.sv
// Beat FIFO plus skew pipeline that turns DMA beats (A column, B row) into the
// diagonally staggered operand wavefront an NxN systolic array expects.
module systolic_axis_feeder #(
    parameter int N          = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int K_WIDTH    = 8
) (
    input  logic                            axi_clk,
    input  logic                            axi_rst,
    input  logic                            s_axis_valid,
    input  logic [2*N*DATA_WIDTH-1:0]       s_axis_data,
    output logic                            s_axis_ready,
    input  logic                            start,
    input  logic [K_WIDTH-1:0]              cfg_k,
    output logic [N*DATA_WIDTH-1:0]         a_feed,
    output logic [N*DATA_WIDTH-1:0]         b_feed,
    output logic                            feed_en,
    output logic                            busy,
    output logic                            tile_done,
    output logic [$clog2(DEPTH+1)-1:0]      fifo_count
);

    localparam int DW = DATA_WIDTH;
    localparam int BW = 2 * N * DW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [K_WIDTH-1:0]   remCount_q, remCount_d;
    logic [FW-1:0]        flushCount_q, flushCount_d;

    logic [BW-1:0]        fifoMem [DEPTH];
    logic [PW-1:0]        wrPtr_q, rdPtr_q;
    logic [CW-1:0]        count_q;
    logic [BW-1:0]        headBeat;
    logic                 push, pop, advance;

    logic [DW-1:0]        aSkew_q [N][N];
    logic [DW-1:0]        bSkew_q [N][N];
    logic [DW-1:0]        newA [N];
    logic [DW-1:0]        newB [N];
    logic                 feedEn_q, tileDone_q;

    // Ready is gated by reset so the DMA never sees a slot while state is cleared.
    assign s_axis_ready = !axi_rst && (count_q != CW'(DEPTH));
    assign push         = s_axis_valid && s_axis_ready;
    assign pop          = (state_q == STREAM) && (count_q != '0);
    assign headBeat     = fifoMem[rdPtr_q];
    assign fifo_count   = count_q;

    always_ff @(posedge axi_clk) begin
        if (push) begin
            fifoMem[wrPtr_q] <= s_axis_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q      <= IDLE;
            remCount_q   <= '0;
            flushCount_q <= '0;
        end else begin
            state_q      <= state_d;
            remCount_q   <= remCount_d;
            flushCount_q <= flushCount_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        remCount_d   = remCount_q;
        flushCount_d = flushCount_q;
        advance      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_k != '0) begin
                        state_d    = STREAM;
                        remCount_d = cfg_k;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            STREAM: begin
                if (pop) begin
                    advance    = 1'b1;
                    remCount_d = remCount_q - 1'b1;
                    if (remCount_q == K_WIDTH'(1)) begin
                        if (N > 1) begin
                            state_d      = FLUSH;
                            flushCount_d = FW'(N - 1);
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            FLUSH: begin
                advance      = 1'b1;
                flushCount_d = flushCount_q - 1'b1;
                if (flushCount_q == FW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only STREAM feeds real data; FLUSH shifts zeros to drain the diagonal tail.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            newA[i] = '0;
            newB[i] = '0;
            if (state_q == STREAM) begin
                newA[i] = headBeat[i*DW +: DW];
                newB[i] = headBeat[(N+i)*DW +: DW];
            end
        end
    end

    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    aSkew_q[i][j] <= '0;
                    bSkew_q[i][j] <= '0;
                end
            end
            feedEn_q   <= 1'b0;
            tileDone_q <= 1'b0;
        end else begin
            feedEn_q   <= advance;
            tileDone_q <= (state_q == DONE);
            if (advance) begin
                for (int i = 0; i < N; i++) begin
                    aSkew_q[i][0] <= newA[i];
                    bSkew_q[i][0] <= newB[i];
                    for (int j = 1; j < N; j++) begin
                        aSkew_q[i][j] <= aSkew_q[i][j-1];
                        bSkew_q[i][j] <= bSkew_q[i][j-1];
                    end
                end
            end
        end
    end

    // Lane i taps its chain at depth i, giving the i-step diagonal delay.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign a_feed[i*DW +: DW] = aSkew_q[i][i];
        assign b_feed[i*DW +: DW] = bSkew_q[i][i];
    end

    assign feed_en   = feedEn_q;
    assign tile_done = tileDone_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/systolic_axis_feeder.md
SYSTOLIC_AXIS_FEEDER -- requirements
Module: systolic_axis_feeder

Interface
REQ-001 Parameter N, default 3: systolic array dimension; number of A rows and B columns fed per beat.
REQ-002 Parameter DATA_WIDTH, default 8: element width in bits.
REQ-003 Parameter DEPTH, default 16: beat FIFO depth; power of two, at least 2.
REQ-004 Parameter K_WIDTH, default 8: width of cfg_k.
REQ-005 axi_clk  in  1: single clock; all logic rises on posedge.
REQ-006 axi_rst  in  1: asynchronous, active-high reset.
REQ-007 s_axis_valid  in  1: DMA beat valid.
REQ-008 s_axis_data  in  2*N*DATA_WIDTH: beat; low half is A column (element i at bits [i*DW +: DW]), high half is B row in the same layout.
REQ-009 s_axis_ready  out  1: block accepts a beat.
REQ-010 start  in  1: one-cycle request to stream one tile.
REQ-011 cfg_k  in  K_WIDTH: beats per tile (inner dimension); sampled at accepted start.
REQ-012 a_feed  out  N*DATA_WIDTH: skewed A elements to array row inputs.
REQ-013 b_feed  out  N*DATA_WIDTH: skewed B elements to array column inputs.
REQ-014 feed_en  out  1: array clock-enable; a_feed/b_feed valid and array advances only when high.
REQ-015 busy  out  1: high in every state except IDLE.
REQ-016 tile_done  out  1: one-cycle pulse at tile completion.
REQ-017 fifo_count  out  $clog2(DEPTH+1): beats currently held.

Function
REQ-018 FIFO SHALL store whole 2*N*DW beats; a push occurs when s_axis_valid && s_axis_ready.
REQ-019 s_axis_ready SHALL equal (fifo_count != DEPTH) and SHALL NOT depend combinationally on s_axis_valid.
REQ-020 Simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-021 FSM states SHALL be IDLE, STREAM, FLUSH, DONE.
REQ-022 IDLE -> STREAM on start with cfg_k != 0; count register loads cfg_k. start with cfg_k == 0 -> DONE directly.
REQ-023 start outside IDLE SHALL be ignored; cfg_k changes after the sampled start have no effect.
REQ-024 In STREAM, a pop SHALL occur each cycle the FIFO is non-empty; feed_en is high on the cycle after a pop and low otherwise. FIFO empty mid-tile yields a bubble: the skew pipeline holds and feed_en is 0.
REQ-025 STREAM -> FLUSH on the pop that brings the remaining count to 0.
REQ-026 FLUSH SHALL produce exactly N-1 enabled steps (feed_en high), shifting zeros into the skew pipeline, then -> DONE.
REQ-027 DONE SHALL assert tile_done for one cycle, then -> IDLE.
REQ-028 Skew: element i of the popped A and B halves SHALL appear on a_feed/b_feed lane i after i additional enabled steps; lane 0 appears on the cycle after the pop.
REQ-029 Lanes with no data yet (pipeline fill) and lanes past the tile end SHALL present 0.
REQ-030 Total enabled steps per tile SHALL be cfg_k + N - 1; beats beyond cfg_k remain in the FIFO for the next tile.
REQ-031 The FIFO SHALL accept pushes in every state, including IDLE (prefetch).

Reset
REQ-032 axi_rst SHALL asynchronously clear the FIFO pointers and fifo_count, set FSM to IDLE, and zero the skew registers; outputs: s_axis_ready=0 while axi_rst is high, then 1; a_feed=0, b_feed=0, feed_en=0, busy=0, tile_done=0.
REQ-033 Reset mid-tile SHALL discard all buffered beats and any partial tile; no tile_done is produced.

Verification
REQ-034 N=3, DEPTH=4: push beats A={1,2,3},B={4,5,6} and A={7,8,9},B={10,11,12}; start with cfg_k=2 -> 4 enabled steps; a_feed lane0 = 1,7,0,0; lane1 = 0,2,8,0; lane2 = 0,0,3,9; b_feed analogous; tile_done 1 cycle after the last step.
REQ-035 Push 4 beats with no start -> fifo_count=4, s_axis_ready=0; 5th beat held by DMA until a pop, then accepted.
REQ-036 start with cfg_k=3 and only 1 beat buffered -> feed_en low for the gap; outputs frozen; resume on later pushes; sequence identical to no-gap case apart from bubbles.
REQ-037 start with cfg_k=0 -> no feed_en, tile_done two cycles after start, FIFO untouched.
REQ-038 Assert axi_rst during FLUSH -> all outputs 0 immediately, fifo_count=0, no tile_done; a fresh tile afterwards behaves as REQ-034.
REQ-039 Push and pop on the same cycle at fifo_count=2 -> fifo_count stays 2; FIFO order preserved across pointer wrap.
